// File: rtl/ebus_pkg.sv
// Shared EBUS constants, lane slice type and lane boundary helpers.
package ebus_pkg;

  localparam int EBUS_WIDTH  = 36;
  localparam int EBUS_NLANE  = 6;
  localparam int EBUS_LANE_W = EBUS_WIDTH / EBUS_NLANE;

  // One lane's worth of EBUS data, bit 0 = most significant as on the backplane.
  typedef logic [0:EBUS_LANE_W-1] tEBUSlane;

  // First EBUS bit index of lane k.
  function automatic int lane_lo(input int k, input int lw = EBUS_LANE_W);
    return k * lw;
  endfunction

  // Last EBUS bit index of lane k.
  function automatic int lane_hi(input int k, input int lw = EBUS_LANE_W);
    return k * lw + lw - 1;
  endfunction

endpackage

// File: rtl/ebus_lane_sel.sv
// Fixed-priority encoder for one EBUS lane: lowest requesting channel wins.
module ebus_lane_sel
  import ebus_pkg::*;
#(
  parameter  int NDRV = 32,
  localparam int IW   = $clog2(NDRV)
) (
  input  logic [NDRV-1:0] req_i,
  output logic [IW-1:0]   win_o,
  output logic            any_o,
  output logic            multi_o
);

  // Scan from the top down so the lowest requesting index is left in win_o.
  always_comb begin
    win_o = '0;
    for (int i = NDRV - 1; i >= 0; i--) begin
      if (req_i[i]) win_o = IW'(i);
    end
  end

  assign any_o   = |req_i;
  // Clearing the lowest set bit leaves something only if two or more requested.
  assign multi_o = |(req_i & (req_i - NDRV'(1)));

endmodule

// File: rtl/ebus_lane_arbiter.sv
// Registered per-lane EBUS merge with sticky contention capture and stuck-driver watchdog.
module ebus_lane_arbiter
  import ebus_pkg::*;
#(
  parameter  int NDRV      = 32,
  parameter  int WIDTH     = EBUS_WIDTH,
  parameter  int NLANE     = EBUS_NLANE,
  parameter  int TIMEOUT   = 255,
  parameter  int IDLE_HOLD = 0,
  localparam int IW        = $clog2(NDRV),
  localparam int LW        = WIDTH / NLANE,
  localparam int CW        = $clog2(TIMEOUT + 2)
) (
  input  logic                          clk,
  input  logic                          crobar_l,
  input  logic [NDRV-1:0]               drv_driving,
  input  logic [NDRV-1:0][0:WIDTH-1]    drv_data,
  input  logic [NDRV-1:0][0:NLANE-1]    drv_lane_en,
  output logic [0:WIDTH-1]              ebus_data,
  output logic                          ebus_valid,
  output logic [0:NLANE-1][IW-1:0]      lane_owner,
  output logic                          contention,
  output logic [NDRV-1:0]               contention_map,
  output logic                          stuck,
  output logic [IW-1:0]                 stuck_owner,
  input  logic                          err_clr
);

  logic [0:NLANE-1][NDRV-1:0] lane_req;
  logic [0:NLANE-1][IW-1:0]   lane_win;
  logic [0:NLANE-1]           lane_any;
  logic [0:NLANE-1]           lane_multi;

  logic [0:WIDTH-1]         data_d, data_q;
  logic                     valid_d, valid_q;
  logic [0:NLANE-1][IW-1:0] owner_d, owner_q;
  logic                     cont_d, cont_q;
  logic [NDRV-1:0]          map_d, map_q;
  logic                     stuck_d, stuck_q;
  logic [IW-1:0]            stuck_own_d, stuck_own_q;
  logic [CW-1:0]            cnt_d, cnt_q;
  logic [IW-1:0]            wd_owner_d, wd_owner_q;
  logic                     wd_any;
  logic                     cont_ev;
  logic [NDRV-1:0]          map_ev;
  logic                     stuck_ev;

  // Build each lane's request set from the drive strobes and lane enables.
  always_comb begin
    lane_req = '0;
    for (int k = 0; k < NLANE; k++) begin
      for (int i = 0; i < NDRV; i++) begin
        lane_req[k][i] = drv_driving[i] & drv_lane_en[i][k];
      end
    end
  end

  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    ebus_lane_sel #(.NDRV(NDRV)) u_sel (
      .req_i   (lane_req[g]),
      .win_o   (lane_win[g]),
      .any_o   (lane_any[g]),
      .multi_o (lane_multi[g])
    );
  end

  // Merge winning slices; idle lanes either clear or keep their last value.
  always_comb begin
    data_d  = (IDLE_HOLD != 0) ? data_q  : '0;
    owner_d = (IDLE_HOLD != 0) ? owner_q : '0;
    for (int k = 0; k < NLANE; k++) begin
      if (lane_any[k]) begin
        data_d[lane_lo(k, LW) +: LW] = drv_data[lane_win[k]][lane_lo(k, LW) +: LW];
        owner_d[k]                   = lane_win[k];
      end
    end
    valid_d = |lane_any;
  end

  // Contention capture: a new event always sets, and reloads the map unless one is already latched.
  always_comb begin
    cont_ev = |lane_multi;
    map_ev  = '0;
    for (int k = 0; k < NLANE; k++) begin
      if (lane_multi[k]) map_ev = map_ev | lane_req[k];
    end
    cont_d = cont_q;
    map_d  = map_q;
    if (err_clr) begin
      cont_d = 1'b0;
      map_d  = '0;
    end
    if (cont_ev) begin
      cont_d = 1'b1;
      if (!cont_q || err_clr) map_d = map_ev;
    end
  end

  // Watchdog: count how long the overall highest-priority driver has held the bus.
  always_comb begin
    wd_owner_d = '0;
    for (int i = NDRV - 1; i >= 0; i--) begin
      if (drv_driving[i]) wd_owner_d = IW'(i);
    end
    wd_any = |drv_driving;
    cnt_d  = cnt_q;
    if (!wd_any) begin
      cnt_d = '0;
    end else if (cnt_q == '0 || wd_owner_d != wd_owner_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q < CW'(TIMEOUT + 1)) begin
      cnt_d = cnt_q + CW'(1);
    end
    stuck_ev    = (cnt_q == CW'(TIMEOUT + 1));
    stuck_d     = stuck_q;
    stuck_own_d = stuck_own_q;
    if (err_clr) begin
      stuck_d     = 1'b0;
      stuck_own_d = '0;
    end
    if (stuck_ev && (!stuck_q || err_clr)) begin
      stuck_d     = 1'b1;
      stuck_own_d = wd_owner_q;
    end else if (stuck_ev) begin
      stuck_d = 1'b1;
    end
  end

  // All state registers; crobar drops everything immediately.
  always_ff @(posedge clk or negedge crobar_l) begin
    if (!crobar_l) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      owner_q     <= '0;
      cont_q      <= 1'b0;
      map_q       <= '0;
      stuck_q     <= 1'b0;
      stuck_own_q <= '0;
      cnt_q       <= '0;
      wd_owner_q  <= '0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      owner_q     <= owner_d;
      cont_q      <= cont_d;
      map_q       <= map_d;
      stuck_q     <= stuck_d;
      stuck_own_q <= stuck_own_d;
      cnt_q       <= cnt_d;
      wd_owner_q  <= wd_owner_d;
    end
  end

  assign ebus_data      = data_q;
  assign ebus_valid     = valid_q;
  assign lane_owner     = owner_q;
  assign contention     = cont_q;
  assign contention_map = map_q;
  assign stuck          = stuck_q;
  assign stuck_owner    = stuck_own_q;

endmodule

// File: tb/tb_ebus_lane_arbiter.sv
// Directed bench for ebus_lane_arbiter: one clearing/short-timeout instance, one holding instance.
module tb_ebus_lane_arbiter;

  localparam int NDRV  = 32;
  localparam int WIDTH = 36;
  localparam int NLANE = 6;
  localparam int IW    = 5;

  logic                       clk;
  logic                       crobar_l;
  logic [NDRV-1:0]            drv_driving;
  logic [NDRV-1:0][0:WIDTH-1] drv_data;
  logic [NDRV-1:0][0:NLANE-1] drv_lane_en;
  logic                       err_clr;

  logic [0:WIDTH-1]         data0, data1;
  logic                     valid0, valid1;
  logic [0:NLANE-1][IW-1:0] owner0, owner1;
  logic                     cont0, cont1;
  logic [NDRV-1:0]          map0, map1;
  logic                     stuck0, stuck1;
  logic [IW-1:0]            stuckOwn0, stuckOwn1;

  int errorCount = 0;
  int checkCount = 0;

  ebus_lane_arbiter #(.NDRV(NDRV), .WIDTH(WIDTH), .NLANE(NLANE), .TIMEOUT(4), .IDLE_HOLD(0)) dut0 (
    .clk(clk), .crobar_l(crobar_l), .drv_driving(drv_driving), .drv_data(drv_data),
    .drv_lane_en(drv_lane_en), .ebus_data(data0), .ebus_valid(valid0), .lane_owner(owner0),
    .contention(cont0), .contention_map(map0), .stuck(stuck0), .stuck_owner(stuckOwn0),
    .err_clr(err_clr)
  );

  ebus_lane_arbiter #(.NDRV(NDRV), .WIDTH(WIDTH), .NLANE(NLANE), .TIMEOUT(255), .IDLE_HOLD(1)) dut1 (
    .clk(clk), .crobar_l(crobar_l), .drv_driving(drv_driving), .drv_data(drv_data),
    .drv_lane_en(drv_lane_en), .ebus_data(data1), .ebus_valid(valid1), .lane_owner(owner1),
    .contention(cont1), .contention_map(map1), .stuck(stuck1), .stuck_owner(stuckOwn1),
    .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearInputs();
    drv_driving = '0;
    drv_data    = '0;
    drv_lane_en = '0;
    err_clr     = 1'b0;
  endtask

  // Add one channel's drive request on top of whatever is already applied.
  task automatic applyStimulus(input int ch, input logic [0:WIDTH-1] data, input logic [0:NLANE-1] en);
    drv_driving[ch] = 1'b1;
    drv_data[ch]    = data;
    drv_lane_en[ch] = en;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:NLANE-1] laneBit(input int k);
    logic [0:NLANE-1] m;
    m    = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  // Every lane of the word carries the channel number.
  function automatic logic [0:WIDTH-1] chanWord(input int ch);
    logic [5:0] s;
    s = 6'(ch);
    return {6{s}};
  endfunction

  localparam logic [0:NLANE-1] FULL = 6'b111111;

  initial begin
    clearInputs();
    crobar_l = 1'b0;
    #3;
    checkOutput("rst_data", data0, 0);
    checkOutput("rst_valid", valid0, 0);
    checkOutput("rst_owner", owner0, 0);
    checkOutput("rst_cont", cont0, 0);
    checkOutput("rst_stuck", stuck0, 0);
    checkOutput("rst_data_hold", data1, 0);
    @(negedge clk);
    crobar_l = 1'b1;

    // Single full-word driver, then release.
    applyStimulus(3, 36'o123456701234, FULL);
    tick();
    checkOutput("full_data", data0, 36'o123456701234);
    checkOutput("full_valid", valid0, 1);
    checkOutput("full_owner", owner0, {6{5'd3}});
    checkOutput("full_cont", cont0, 0);
    clearInputs();
    tick();
    checkOutput("idle0_data", data0, 0);
    checkOutput("idle0_valid", valid0, 0);
    checkOutput("idle0_owner", owner0, 0);
    checkOutput("hold_data", data1, 36'o123456701234);
    checkOutput("hold_valid", valid1, 0);
    checkOutput("hold_owner", owner1, {6{5'd3}});

    // Sliced share, one channel per lane.
    applyStimulus(7, chanWord(7), laneBit(0));
    for (int c = 8; c <= 12; c++) applyStimulus(c, chanWord(c), laneBit(13 - c));
    tick();
    checkOutput("slice_data", data0, {6'd7, 6'd12, 6'd11, 6'd10, 6'd9, 6'd8});
    checkOutput("slice_owner", owner0, {5'd7, 5'd12, 5'd11, 5'd10, 5'd9, 5'd8});
    checkOutput("slice_valid", valid0, 1);
    checkOutput("slice_cont", cont0, 0);

    // Contention on lane 3, then a second collision, then clear.
    clearInputs();
    applyStimulus(2, 36'o111111111111, laneBit(3));
    applyStimulus(5, 36'o555555555555, laneBit(3));
    tick();
    checkOutput("cont1_flag", cont0, 1);
    checkOutput("cont1_map", map0, 32'h24);
    checkOutput("cont1_data", data0, 36'o000000110000);
    checkOutput("cont1_owner", owner0, {5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0});
    clearInputs();
    applyStimulus(1, chanWord(1), FULL);
    applyStimulus(4, chanWord(4), FULL);
    tick();
    checkOutput("cont2_flag", cont0, 1);
    checkOutput("cont2_map", map0, 32'h24);
    checkOutput("cont2_data", data0, 36'o010101010101);
    checkOutput("cont2_owner", owner0, {6{5'd1}});
    clearInputs();
    err_clr = 1'b1;
    tick();
    checkOutput("clr_flag", cont0, 0);
    checkOutput("clr_map", map0, 0);

    // err_clr coincident with a new contention: the new event wins and reloads the map.
    clearInputs();
    applyStimulus(1, chanWord(1), FULL);
    applyStimulus(4, chanWord(4), FULL);
    tick();
    checkOutput("pre_map", map0, 32'h12);
    clearInputs();
    err_clr = 1'b1;
    applyStimulus(2, 36'o111111111111, laneBit(3));
    applyStimulus(5, 36'o555555555555, laneBit(3));
    tick();
    checkOutput("setwin_flag", cont0, 1);
    checkOutput("setwin_map", map0, 32'h24);
    clearInputs();
    err_clr = 1'b1;
    tick();
    checkOutput("setwin_clr", cont0, 0);
    clearInputs();

    // Idle policy with a small word.
    applyStimulus(0, 36'o777, FULL);
    tick();
    checkOutput("o777_data0", data0, 36'o777);
    checkOutput("o777_data1", data1, 36'o777);
    clearInputs();
    tick();
    checkOutput("o777_idle0", data0, 0);
    checkOutput("o777_valid0", valid0, 0);
    checkOutput("o777_hold1", data1, 36'o777);
    checkOutput("o777_valid1", valid1, 0);

    // Watchdog: ch6 for five cycles trips on the following output cycle.
    for (int n = 0; n < 5; n++) begin
      clearInputs();
      applyStimulus(6, chanWord(6), FULL);
      tick();
      checkOutput($sformatf("wd_hold%0d", n), stuck0, 0);
    end
    clearInputs();
    tick();
    checkOutput("wd_stuck", stuck0, 1);
    checkOutput("wd_owner", stuckOwn0, 6);
    checkOutput("wd_long_to", stuck1, 0);
    err_clr = 1'b1;
    tick();
    checkOutput("wd_clr", stuck0, 0);

    // Owner change before timeout restarts the count.
    clearInputs();
    for (int n = 0; n < 4; n++) begin
      applyStimulus(6, chanWord(6), FULL);
      tick();
    end
    clearInputs();
    for (int n = 0; n < 3; n++) begin
      applyStimulus(7, chanWord(7), FULL);
      tick();
    end
    clearInputs();
    tick();
    checkOutput("wd_switch", stuck0, 0);

    // Asynchronous reset in the middle of a contended transfer.
    applyStimulus(5, chanWord(5), FULL);
    applyStimulus(9, chanWord(9), FULL);
    tick();
    checkOutput("arst_pre_cont", cont0, 1);
    checkOutput("arst_pre_valid", valid0, 1);
    #2;
    crobar_l = 1'b0;
    #1;
    checkOutput("arst_data", data0, 0);
    checkOutput("arst_valid", valid0, 0);
    checkOutput("arst_cont", cont0, 0);
    checkOutput("arst_map", map0, 0);
    checkOutput("arst_owner", owner0, 0);
    checkOutput("arst_hold", data1, 0);
    clearInputs();
    @(negedge clk);
    crobar_l = 1'b1;
    tick();
    checkOutput("arst_after", data1, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
